core_word_serializer: RTL and testbench

//  Per-core stage downstream of the pipe-in arbiter; 8 instances, one per NeuRRAM core.

---
 rtl/core_word_serializer.sv | 196 +++++++++++++++++++
 tb/tb_core_word_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_word_serializer.sv
// core_word_serializer: buffers 32-bit words from the pipe-in arbiter in a
// single-clock FIFO and shifts each word bit-serially into one NeuRRAM core's
// shift register, finishing every word with a one-cycle latch pulse.
module core_word_serializer #(
    parameter int DEPTH     = 16,  // FIFO depth in words, power of 2, >= 2
    parameter int WORD_W    = 32,  // word width and bits shifted per word
    parameter int SHIFT_DIV = 4,   // clk cycles per sr_clk phase, >= 1
    parameter int MSB_FIRST = 1    // 1: bit WORD_W-1 first, 0: bit 0 first
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_W-1:0]      din,
    input  logic                   wr_en,
    output logic                   ready,
    input  logic                   shift_en,
    output logic                   sr_data,
    output logic                   sr_clk,
    output logic                   sr_latch,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int PH_W  = $clog2(SHIFT_DIV) + 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SHIFT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH
    } state_e;

    // FIFO storage and pointers
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Serializer state
    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              sr_data_q, sr_data_d;
    logic              sr_clk_q, sr_clk_d;
    logic              sr_latch_q, sr_latch_d;

    logic push;
    logic pop;
    logic start_ok;

    // The bit presented first on sr_data for a given word.
    function automatic logic lead_bit(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_W-1] : w[0];
    endfunction

    // Advance the shift register by one bit toward the output end.
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // ready looks at the registered (pre-pop) level, so a full FIFO still
    // refuses a write in the same cycle as the LOAD pop.
    assign ready    = (level_q < LVL_FULL);
    assign push     = wr_en && ready;
    assign pop      = (state_q == S_LOAD);
    assign start_ok = (level_q != '0) && shift_en;

    assign level    = level_q;
    assign busy     = (state_q != S_IDLE);
    assign sr_data  = sr_data_q;
    assign sr_clk   = sr_clk_q;
    assign sr_latch = sr_latch_q;

    // FIFO occupancy and pointer update
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Serializer next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        sr_data_d  = sr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d   = mem_q[rd_ptr_q];
                sr_data_d = lead_bit(mem_q[rd_ptr_q]);
                bit_cnt_d = '0;
                phase_d   = '0;
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = advance(shift_q);
                        sr_data_d = lead_bit(advance(shift_q));
                        state_d   = S_SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_LATCH: begin
                state_d = start_ok ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // sr_clk and sr_latch are registered copies of the state being entered,
        // so they are high exactly for the SHIFT_HI and LATCH cycles.
        sr_clk_d   = (state_d == S_SHIFT_HI);
        sr_latch_d = (state_d == S_LATCH);
    end

    // FIFO data write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // level are, so stale contents can never be read out.
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from the
        // same pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            sr_data_q  <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            sr_data_q  <= sr_data_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
        end
    end

endmodule

// File: tb/tb_core_word_serializer.sv
// Testbench for core_word_serializer: a cycle-level occupancy/timing model
// (word occupies 1 + 2*SHIFT_DIV*WORD_W + 1 cycles after its LOAD) predicts
// every output each cycle; output monitors rebuild the shifted words.
module tb_core_word_serializer;

    localparam int W   = 32;
    localparam int SD  = 4;
    localparam int DEP = 16;
    localparam int LEN = 2 + 2 * SD * W;  // cycles per word, LOAD..LATCH

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic        wr_en, shift_en;
    logic        ready, sr_data, sr_clk, sr_latch, busy;
    logic [4:0]  level;

    logic [31:0] b_din;
    logic        b_wr_en, b_shift_en;
    logic        b_ready, b_sr_data, b_sr_clk, b_sr_latch, b_busy;
    logic [2:0]  b_level;

    core_word_serializer dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .ready(ready),
        .shift_en(shift_en), .sr_data(sr_data), .sr_clk(sr_clk),
        .sr_latch(sr_latch), .busy(busy), .level(level)
    );

    core_word_serializer #(.DEPTH(4), .WORD_W(32), .SHIFT_DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .wr_en(b_wr_en), .ready(b_ready),
        .shift_en(b_shift_en), .sr_data(b_sr_data), .sr_clk(b_sr_clk),
        .sr_latch(b_sr_latch), .busy(b_busy), .level(b_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: queued words, position within the current word
    // (-1 when idle), word being shifted and the held serial data value.
    logic [31:0] m_q[$];
    logic [31:0] m_done[$];
    int          m_pos  = -1;
    logic [31:0] m_cur  = '0;
    logic        m_data = 1'b0;

    // Monitors: rebuild words from sr_data at each sr_clk rise.
    logic [31:0] got_q[$], b_got_q[$];
    int          got_n[$], b_got_n[$], lat_cyc[$];
    logic [31:0] a_acc, b_acc;
    int          a_nbits = 0, b_nbits = 0;
    logic        a_prev_clk = 1'b0, b_prev_clk = 1'b0;

    always @(negedge clk) begin
        a_prev_clk <= sr_clk;
        if (busy !== 1'b1) begin
            a_nbits <= 0;
        end else if (sr_clk && !a_prev_clk) begin
            a_acc   <= {a_acc[30:0], sr_data};
            a_nbits <= a_nbits + 1;
        end else if (sr_latch) begin
            got_q.push_back(a_acc);
            got_n.push_back(a_nbits);
            lat_cyc.push_back(cyc);
            a_nbits <= 0;
        end
    end

    always @(negedge clk) begin
        b_prev_clk <= b_sr_clk;
        if (b_busy !== 1'b1) begin
            b_nbits <= 0;
        end else if (b_sr_clk && !b_prev_clk) begin
            b_acc   <= {b_sr_data, b_acc[31:1]};
            b_nbits <= b_nbits + 1;
        end else if (b_sr_latch) begin
            b_got_q.push_back(b_acc);
            b_got_n.push_back(b_nbits);
            b_nbits <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    // One clock cycle: compare outputs against the model, apply inputs,
    // advance the model across the coming edge, then step to #1 after it.
    task automatic cycle(input logic w, input logic [31:0] d, input logic se, input logic rs);
        int   k;
        int   cnt;
        logic exp_clk;
        logic start;
        logic push;
        exp_clk = 1'b0;
        if (m_pos >= 1 && m_pos <= 2 * SD * W) begin
            k       = m_pos - 1;
            exp_clk = (k % (2 * SD)) >= SD;
            m_data  = m_cur[31 - k / (2 * SD)];
        end
        check("sr_clk",   sr_clk,   exp_clk);
        check("sr_data",  sr_data,  m_data);
        check("sr_latch", sr_latch, m_pos == LEN - 1);
        check("busy",     busy,     m_pos >= 0);
        check("level",    level,    m_q.size());
        check("ready",    ready,    m_q.size() < DEP);
        if (n_total - n_pass >= 40) finish_run();

        wr_en = w; din = d; shift_en = se; rst_n = rs;

        cnt = m_q.size();
        if (!rs) begin
            m_q.delete();
            m_pos  = -1;
            m_data = 1'b0;
        end else begin
            start = (cnt > 0) && se;
            push  = w && (cnt < DEP);
            if (m_pos == 0) m_cur = m_q.pop_front();
            if (m_pos == LEN - 1) m_done.push_back(m_cur);
            if (push) m_q.push_back(d);
            if (m_pos >= 0 && m_pos < LEN - 1) m_pos = m_pos + 1;
            else m_pos = start ? 0 : -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          base;
        int          load_c;
        int          lat_c;
        logic [31:0] w17;

        rst_n = 1'b0; din = '0; wr_en = 1'b0; shift_en = 1'b0;
        b_din = '0; b_wr_en = 1'b0; b_shift_en = 1'b0;
        @(posedge clk);
        #1;

        // T1: single word, MSB first, latch 257 cycles after LOAD.
        cycle(1'b1, 32'hA500_0001, 1'b1, 1'b1);
        for (int i = 0; i < 270; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t1_words", got_q.size(), 1);
        if (got_q.size() >= 1) check("t1_word", got_q[0], 32'hA500_0001);

        // T2: fill to 16 with shift disabled; 17th waits for the first pop.
        w17 = $urandom;
        for (int i = 0; i < 17; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
        check("t2_level_full", level, 16);
        check("t2_ready_full", ready, 0);
        cycle(1'b1, w17, 1'b1, 1'b1);
        check("t2_load_busy", busy, 1);
        check("t2_ready_at_load", ready, 0);
        cycle(1'b1, w17, 1'b1, 1'b1);
        check("t2_level_after_pop", level, 15);
        check("t2_ready_after_pop", ready, 1);
        cycle(1'b1, w17, 1'b1, 1'b1);
        check("t2_17th_accepted", level, 16);
        for (int i = 0; i < 17 * LEN + 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // T3: three queued words run back to back, latches 258 apart.
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
        base = lat_cyc.size();
        for (int i = 0; i < 3 * LEN + 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t3_latches", lat_cyc.size() - base, 3);
        if (lat_cyc.size() - base == 3) begin
            check("t3_gap1", lat_cyc[base + 1] - lat_cyc[base], LEN);
            check("t3_gap2", lat_cyc[base + 2] - lat_cyc[base + 1], LEN);
        end

        // T4: shift_en dropped during bit 10 of word 1 of 2.
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 2 + 10 * 2 * SD + 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < LEN + 40; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("t4_level", level, 1);
        check("t4_idle", busy, 0);
        for (int i = 0; i < LEN + 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // T5: reset during bit 5 with 4 words still buffered.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 2 + 5 * 2 * SD + 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t5_busy_before", busy, 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t5_level", level, 0);
        check("t5_ready", ready, 1);
        check("t5_sr_clk", sr_clk, 0);
        check("t5_busy", busy, 0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with random shift permission, then drain.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) != 0, 1'b1);
        for (int i = 0; i < 5000 && !(m_pos < 0 && m_q.size() == 0); i++)
            cycle(1'b0, '0, 1'b1, 1'b1);
        check("drain_busy", busy, 0);
        check("drain_level", level, 0);

        check("words_seen", got_q.size(), m_done.size());
        for (int i = 0; i < got_q.size() && i < m_done.size(); i++) begin
            check("word_value", got_q[i], m_done[i]);
            check("word_bits", got_n[i], W);
        end

        // T6: LSB first, one clk per phase, word 3.
        b_wr_en = 1'b1; b_din = 32'h0000_0003; b_shift_en = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b1);
        b_wr_en = 1'b0;
        load_c = -1;
        lat_c  = -1;
        for (int i = 0; i < 80; i++) begin
            if (b_busy === 1'b1 && load_c < 0) load_c = i;
            if (b_sr_latch === 1'b1 && lat_c < 0) lat_c = i;
            if (load_c >= 0 && i > load_c && i <= load_c + 64) begin
                check("t6_sr_clk", b_sr_clk, (i - load_c - 1) % 2);
                check("t6_sr_data", b_sr_data, ((i - load_c - 1) / 2) < 2);
            end
            cycle(1'b0, '0, 1'b1, 1'b1);
        end
        check("t6_load_seen", load_c, 1);
        check("t6_latch_delay", lat_c - load_c, 1 + 2 * 1 * W);
        check("t6_level", b_level, 0);
        check("t6_words", b_got_q.size(), 1);
        if (b_got_q.size() >= 1) begin
            check("t6_word", b_got_q[0], 32'h0000_0003);
            check("t6_bits", b_got_n[0], W);
        end

        finish_run();
    end

endmodule
